// File: rtl/pipe_alu_if.sv
// pipe_alu_if: operand/result bus for pipe_alu.
//   Input side : in_valid, in_ready, a, b, op, in_tag
//   Output side: out_valid, out_ready, z, zero, neg, carry, ovf, out_tag
// Modports:
//   slave  - the ALU view (consumes operands, produces results)
//   master - the surrounding view (operand source plus result consumer)
interface pipe_alu_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, a, b, op, in_tag, out_ready,
    output in_ready, out_valid, z, zero, neg, carry, ovf, out_tag
  );

  modport master (
    output in_valid, a, b, op, in_tag, out_ready,
    input  in_ready, out_valid, z, zero, neg, carry, ovf, out_tag
  );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu: three-stage pipelined ALU with valid/ready flow control and tag passthrough.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; discards everything in flight
//   bus  - pipe_alu_if.slave: operands/op/tag in, result/flags/tag out
// S1 registers the operands, S2 registers the raw result with carry/ovf, and S3 registers
// the final result with zero/neg. The outputs come straight from the S3 registers.
// All stages share one advance signal, so a blocked consumer freezes the whole pipe.
module pipe_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input logic      clk,
  input logic      rst,
  pipe_alu_if.slave bus
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam logic [WIDTH-1:0] WidthVal = WIDTH[WIDTH-1:0];

  logic advance;

  // S1
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S2
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_carry_q, s2_ovf_q;
  logic [TAG_W-1:0] s2_tag_q;

  // S3
  logic             out_valid_q;
  logic [WIDTH-1:0] z_q;
  logic             zero_q, neg_q, carry_q, ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  // Raw result computed from S1
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d, shift_oob;

  // A held result is the only thing that can block the pipe.
  assign advance     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    shift_oob = (s1_b_q >= WidthVal);
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    case (s1_op_q)
      OpAdd: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OpSub: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];  // borrow: a < b unsigned
        ovf_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OpAnd: res_d = s1_a_q & s1_b_q;
      OpOr:  res_d = s1_a_q | s1_b_q;
      OpXor: res_d = s1_a_q ^ s1_b_q;
      OpShl: res_d = shift_oob ? '0 : (s1_a_q << s1_b_q);
      OpShr: res_d = shift_oob ? '0 : (s1_a_q >> s1_b_q);
      OpSlt: res_d = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      s1_a_q     <= bus.a;
      s1_b_q     <= bus.b;
      s1_op_q    <= bus.op;
      s1_tag_q   <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_carry_q <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_res_q   <= res_d;
      s2_carry_q <= carry_d;
      s2_ovf_q   <= ovf_d;
      s2_tag_q   <= s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_tag_q   <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      z_q         <= s2_res_q;
      zero_q      <= (s2_res_q == '0);
      neg_q       <= s2_res_q[WIDTH-1];
      carry_q     <= s2_carry_q;
      ovf_q       <= s2_ovf_q;
      out_tag_q   <= s2_tag_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised three-stage pipelined ALU with valid/ready flow control, a tag passthrough and a full arithmetic flag set. It is the next generation of the team's 4-bit MiniALU and sits between an operand source and a result consumer. It accepts one operation per cycle and returns results in order, three cycles later, under consumer backpressure.

## Interface
- WIDTH, 8, operand/result width (≥4)
- TAG_W, 4, width of opaque tag carried alongside each operation
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at rising edge
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount for shifts)
- op  in  3  operation select
- in_tag  in  TAG_W  tag, returned unchanged with result
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready at rising edge
- z  out  WIDTH  result
- zero  out  1  z == 0
- neg  out  1  z[WIDTH-1]
- carry  out  1  ADD: carry out; SUB: borrow (a < b unsigned); else 0
- ovf  out  1  ADD/SUB signed overflow; else 0
- out_tag  out  TAG_W  tag of this result

## Operation
- op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SLT (signed a<b → z=1 else 0).
- Arithmetic at WIDTH+1 bits; z is the low WIDTH bits; upper bit feeds carry/borrow.
- ovf ADD: a,b same sign and z sign differs. ovf SUB: a,b signs differ and z sign differs from a.
- Shifts: if b ≥ WIDTH (unsigned), z = 0; else shift by b.
- Stage S1 registers a, b, op, tag, valid. S2 computes raw result plus carry/ovf. S3 registers z, flags, tag, out_valid; outputs are driven directly from S3 registers.
- Global stall: advance = !out_valid || out_ready. When advance is 1, all stages shift one step; otherwise every stage holds. in_ready = advance (combinational from out_valid and out_ready).
- Bubbles (valid=0) propagate like operations. Results never reorder, duplicate or drop.
- Flags belong to the result they accompany and are stable while out_valid && !out_ready.

## Timing
- Reset: all stage valid bits 0, out_valid 0, z 0, zero 0, neg 0, carry 0, ovf 0, out_tag 0. in_ready = 1 during and after reset.
- Reset mid-stream: all in-flight operations are discarded; out_valid is 0 on the cycle after the reset edge.
- Latency: an operation accepted at edge E0 appears at the outputs after edge E2, provided there is no stall. It is consumed at the first edge ≥ E2 with out_ready = 1.
- Throughput: one operation per cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready, in_ready = 0. Input must not be sampled, and all of S1–S3 hold.
- Simultaneous output consume and input accept at the same edge is legal and required for full throughput.
- in_valid = 0 with in_ready = 1 inserts a bubble. out_valid goes low when that bubble reaches S3.
- Operand values outside a transfer cycle are don't-care.

## Test plan
- Reset, then hold out_ready = 1. ADD a=200, b=100, tag=1 → after 3 edges: z=44, carry=1, ovf=0, zero=0, neg=0, out_tag=1.
- SUB 0x80−0x01 → z=0x7F, ovf=1, carry=0, neg=0. SUB 5−5 → z=0, zero=1, carry=0. SUB 3−5 → z=0xFE, carry=1, neg=1.
- Logic/shift/compare: AND 0xF0&0x3C=0x30; OR → 0xFC; XOR 0xFF^0x0F=0xF0; SHL 0x81 by 1 → 0x02; SHR 0x80 by 9 → 0x00, zero=1; SLT a=0xFF, b=0x01 → z=1; SLT a=0x01, b=0xFF → z=0.
- Backpressure: stream tags 0..5 back-to-back. Drop out_ready for 3 cycles once tag 0 is at the output → in_ready=0 and z/flags/out_tag frozen. On release, tags 0..5 emerge in order with no loss or duplication.
- Bubbles: issue tag 0, idle 2 cycles, then tag 1 → out_valid pattern 1,0,0,1 with correct results.
- Reset mid-stream: 3 operations in flight, assert rst for 1 cycle → out_valid=0 and all outputs 0 next cycle. No stale result appears afterwards, and the next accepted operation returns after 3 edges.
